// File: rtl/match_lock_tracker.sv
// Lock tracker behind a 16-bit equality comparator: declares lock after LOCK_COUNT
// consecutive matches, drops it after UNLOCK_COUNT consecutive misses, keeps saturating totals.
module match_lock_tracker #(
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sample_valid,
   input  logic             eq_in,
   input  logic             clear,
   output logic             locked,
   output logic             lock_pulse,
   output logic             unlock_pulse,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] match_total,
   output logic [CNT_W-1:0] miss_total
);

   // sample_valid qualifies eq_in; there is no ready, so every valid sample is consumed in its cycle.
   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [7:0]       LOCK_N   = 8'(LOCK_COUNT);
   localparam logic [7:0]       UNLOCK_N = 8'(UNLOCK_COUNT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [7:0]       run_q, run_d;
   logic [7:0]       run_inc;
   logic             locked_q, locked_d;
   logic             lock_pulse_q, lock_pulse_d;
   logic             unlock_pulse_q, unlock_pulse_d;
   logic [CNT_W-1:0] match_total_q, match_total_d;
   logic [CNT_W-1:0] miss_total_q, miss_total_d;

   assign run_inc = run_q + 8'd1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= S_SEARCH;
         run_q          <= 8'd0;
         locked_q       <= 1'b0;
         lock_pulse_q   <= 1'b0;
         unlock_pulse_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         run_q          <= run_d;
         locked_q       <= locked_d;
         lock_pulse_q   <= lock_pulse_d;
         unlock_pulse_q <= unlock_pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (clear) begin
         state_d = S_SEARCH;
         run_d   = 8'd0;
      end else if (sample_valid) begin
         unique case (state_q)
            S_SEARCH: begin
               if (eq_in) begin
                  if (LOCK_N == 8'd1) begin
                     state_d = S_LOCKED;
                     run_d   = 8'd0;
                  end else begin
                     state_d = S_VERIFY;
                     run_d   = 8'd1;
                  end
               end
            end
            S_VERIFY: begin
               if (!eq_in) begin
                  state_d = S_SEARCH;
                  run_d   = 8'd0;
               end else if (run_inc == LOCK_N) begin
                  state_d = S_LOCKED;
                  run_d   = 8'd0;
               end else begin
                  run_d = run_inc;
               end
            end
            S_LOCKED: begin
               if (!eq_in) begin
                  if (UNLOCK_N == 8'd1) begin
                     state_d = S_SEARCH;
                     run_d   = 8'd0;
                  end else begin
                     state_d = S_HOLD;
                     run_d   = 8'd1;
                  end
               end
            end
            S_HOLD: begin
               if (eq_in) begin
                  state_d = S_LOCKED;
                  run_d   = 8'd0;
               end else if (run_inc == UNLOCK_N) begin
                  state_d = S_SEARCH;
                  run_d   = 8'd0;
               end else begin
                  run_d = run_inc;
               end
            end
            default: begin
               state_d = S_SEARCH;
               run_d   = 8'd0;
            end
         endcase
      end
   end

   // Pulses come from the transition itself; a clear can never produce one.
   always_comb begin
      locked_d       = (state_d == S_LOCKED) || (state_d == S_HOLD);
      lock_pulse_d   = 1'b0;
      unlock_pulse_d = 1'b0;
      if (!clear && sample_valid) begin
         lock_pulse_d   = (state_d == S_LOCKED) &&
                          ((state_q == S_SEARCH) || (state_q == S_VERIFY));
         unlock_pulse_d = (state_d == S_SEARCH) &&
                          ((state_q == S_LOCKED) || (state_q == S_HOLD));
      end
   end

   always_comb begin
      match_total_d = match_total_q;
      miss_total_d  = miss_total_q;
      if (clear) begin
         match_total_d = '0;
         miss_total_d  = '0;
      end else if (sample_valid) begin
         if (eq_in) begin
            if (match_total_q != CNT_MAX) match_total_d = match_total_q + CNT_ONE;
         end else begin
            if (miss_total_q != CNT_MAX) miss_total_d = miss_total_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         match_total_q <= '0;
         miss_total_q  <= '0;
      end else begin
         match_total_q <= match_total_d;
         miss_total_q  <= miss_total_d;
      end
   end

   assign state        = state_q;
   assign locked       = locked_q;
   assign lock_pulse   = lock_pulse_q;
   assign unlock_pulse = unlock_pulse_q;
   assign match_total  = match_total_q;
   assign miss_total   = miss_total_q;

endmodule

// File: doc/match_lock_tracker.md
# match_lock_tracker

Sequential stage directly downstream of the 16-bit equality comparator. Consumes the comparator's 1-bit equal result, qualified by a sample strobe, and tracks whether the two compared streams are in lock.
- Lock is declared after `LOCK_COUNT` consecutive matching samples.
- Lock is dropped after `UNLOCK_COUNT` consecutive mismatching samples.
- Saturating match/miss totals are maintained for status readout.

## Interface
- `LOCK_COUNT`, default 4: consecutive matches required to declare lock. Legal range 1..255.
- `UNLOCK_COUNT`, default 3: consecutive misses required to drop lock. Legal range 1..255.
- `CNT_W`, default 16: width of the total match/miss counters.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `sample_valid`  in  1  `eq_in` is meaningful this cycle.
- `eq_in`  in  1  comparator output (1 = operands equal). Ignored when `sample_valid` = 0.
- `clear`  in  1  synchronous soft clear.
- `locked`  out  1  high in LOCKED and HOLD states.
- `lock_pulse`  out  1  one-cycle pulse on entry to LOCKED from VERIFY or SEARCH.
- `unlock_pulse`  out  1  one-cycle pulse on the transition to SEARCH caused by misses.
- `state`  out  2  SEARCH=0, VERIFY=1, LOCKED=2, HOLD=3.
- `match_total`  out  CNT_W  valid samples with `eq_in`=1, saturating at all-ones.
- `miss_total`  out  CNT_W  valid samples with `eq_in`=0, saturating at all-ones.

## Operation
- Internal run counter: 8 bits, tracks consecutive matches (VERIFY) or consecutive misses (HOLD).
- Priority order, highest first: `reset_n`=0, `clear`=1, `sample_valid`=1. With `sample_valid`=0, state and counters hold and pulses are 0.
- SEARCH:
  - Match, `LOCK_COUNT`=1: go to LOCKED, assert `lock_pulse`.
  - Match, otherwise: go to VERIFY, run=1.
  - Miss: stay in SEARCH.
- VERIFY:
  - Match: run+1. If run+1 = `LOCK_COUNT`, go to LOCKED, assert `lock_pulse`, run=0.
  - Miss: go to SEARCH, run=0.
- LOCKED:
  - Match: stay.
  - Miss, `UNLOCK_COUNT`=1: go to SEARCH, assert `unlock_pulse`.
  - Miss, otherwise: go to HOLD, run=1.
- HOLD:
  - Match: go to LOCKED, run=0. No pulse.
  - Miss: run+1. If run+1 = `UNLOCK_COUNT`, go to SEARCH, assert `unlock_pulse`, run=0.
- Totals:
  - Every valid sample increments exactly one of `match_total` / `miss_total`, independent of state.
  - At all-ones the counter holds; no wrap.
- `clear`:
  - Sets state to SEARCH, zeroes run and both totals, forces both pulses to 0.
  - A sample presented in the same cycle as `clear` is discarded and not counted.
  - Clearing while locked does not produce `unlock_pulse`.

## Timing
- All outputs are registered.
- Reset values: `state`=0 (SEARCH), `locked`=0, `lock_pulse`=0, `unlock_pulse`=0, `match_total`=0, `miss_total`=0.
- Latency: a sample at edge N is reflected in `state`, `locked`, pulses and totals after edge N (visible in cycle N+1).
- Pulses are high for exactly one cycle and never high together.
- Back-to-back samples are accepted every cycle; no backpressure.
- `eq_in` may toggle freely while `sample_valid`=0 with no effect.
- Reset mid-operation (any state, run count, or pulse in flight) returns to reset values at the next edge.

## Test plan
- Reset, then 4 valid matches on consecutive cycles (defaults) -> `state` goes 1,1,1,2; `lock_pulse` high only in the cycle after the 4th sample; `match_total`=4.
- Lock with 4 matches, then miss, miss, match -> `state` 3,3,2; `locked` stays 1 throughout; no `unlock_pulse`; `miss_total`=2.
- Lock, then 3 consecutive misses -> `state` 3,3,0; `unlock_pulse` for one cycle; `locked`=0.
- In VERIFY after 3 matches, `sample_valid`=0 for 5 cycles with `eq_in` toggling, then 1 match -> lock occurs only on that final sample; totals unchanged during the gap.
- Drive `CNT_W`=4 with 20 matches -> `match_total` saturates at 15. Assert `clear` together with a match -> both totals 0, `state`=0, no pulses.
- Lock, then assert `reset_n`=0 for one cycle during HOLD -> all outputs at reset values the next cycle; the next 4 matches re-lock normally.
